// File: rtl/riscv_core_amo_unit.sv
// RV32A atomic sequencer: runs AMO read-modify-write, LR.W and SC.W against the
// data-memory port and keeps the single LR reservation.
module riscv_core_amo_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_kind,
    input  logic [3:0]            i_req_op,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_err,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_err,
    input  logic                  i_store_valid,
    input  logic [ADDR_WIDTH-1:0] i_store_addr,
    output logic                  o_busy
);
    localparam int WW = ADDR_WIDTH - 2;
    localparam logic [1:0] KIND_AMO = 2'b00;
    localparam logic [1:0] KIND_LR  = 2'b01;
    localparam logic [1:0] KIND_SC  = 2'b10;
    localparam logic [1:0] KIND_ILL = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [1:0]            kind_q, kind_d;
    logic [3:0]            op_q, op_d;
    logic [WW-1:0]         word_q, word_d;
    // Holds rs2 until the read returns, then the AMO result that gets written back.
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  resv_valid_q, resv_valid_d;
    logic [WW-1:0]         resv_word_q, resv_word_d;

    logic [WW-1:0] req_word;
    logic [WW-1:0] store_word;
    logic          req_illegal;
    logic          resv_hit;
    logic          unused_store_lsb;

    assign req_word         = i_req_addr[ADDR_WIDTH-1:2];
    assign store_word       = i_store_addr[ADDR_WIDTH-1:2];
    assign unused_store_lsb = ^i_store_addr[1:0];
    assign req_illegal      = (i_req_addr[1:0] != 2'b00) || (i_req_kind == KIND_ILL) ||
                              ((i_req_kind == KIND_AMO) && (i_req_op > 4'd8));
    assign resv_hit         = resv_valid_q && (resv_word_q == req_word);

    function automatic logic [DATA_WIDTH-1:0] amo_calc(input logic [3:0] op,
                                                       input logic [DATA_WIDTH-1:0] old,
                                                       input logic [DATA_WIDTH-1:0] rs2);
        logic signed [DATA_WIDTH-1:0] s_old;
        logic signed [DATA_WIDTH-1:0] s_rs2;
        s_old = old;
        s_rs2 = rs2;
        case (op)
            4'd0:    amo_calc = rs2;
            4'd1:    amo_calc = old + rs2;
            4'd2:    amo_calc = old & rs2;
            4'd3:    amo_calc = old | rs2;
            4'd4:    amo_calc = old ^ rs2;
            4'd5:    amo_calc = (s_rs2 > s_old) ? rs2 : old;
            4'd6:    amo_calc = (s_rs2 < s_old) ? rs2 : old;
            4'd7:    amo_calc = (rs2 > old) ? rs2 : old;
            4'd8:    amo_calc = (rs2 < old) ? rs2 : old;
            default: amo_calc = old;
        endcase
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            kind_q       <= '0;
            op_q         <= '0;
            word_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_word_q  <= '0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            op_q         <= op_d;
            word_q       <= word_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resv_valid_q <= resv_valid_d;
            resv_word_q  <= resv_word_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        op_d         = op_q;
        word_d       = word_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        resv_valid_d = resv_valid_q;
        resv_word_d  = resv_word_q;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    kind_d  = i_req_kind;
                    op_d    = i_req_op;
                    word_d  = req_word;
                    wdata_d = i_req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (i_req_kind == KIND_SC) resv_valid_d = 1'b0;
                    if (req_illegal) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (i_req_kind == KIND_SC) begin
                        if (resv_hit) begin
                            state_d = S_WR_REQ;
                        end else begin
                            rdata_d = DATA_WIDTH'(1);
                            state_d = S_RESP;
                        end
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: if (i_mem_gnt) state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (i_mem_rvalid) begin
                    if (i_mem_err) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (kind_q == KIND_LR) begin
                        rdata_d      = i_mem_rdata;
                        resv_valid_d = 1'b1;
                        resv_word_d  = word_q;
                        state_d      = S_RESP;
                    end else begin
                        rdata_d = i_mem_rdata;
                        wdata_d = amo_calc(op_q, i_mem_rdata, wdata_q);
                        state_d = S_WR_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                if (i_mem_gnt) begin
                    err_d = i_mem_err;
                    if ((kind_q == KIND_AMO) && resv_valid_q && (resv_word_q == word_q))
                        resv_valid_d = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: if (i_resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Comparing against the next value lets a coincident store beat an LR setting it.
        if (i_store_valid && (resv_word_d == store_word)) resv_valid_d = 1'b0;
    end

    always_comb begin
        o_req_ready  = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_resp_valid = 1'b0;
        case (state_q)
            S_IDLE:   o_req_ready = 1'b1;
            S_RD_REQ: o_mem_req = 1'b1;
            S_WR_REQ: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
            end
            S_RESP:   o_resp_valid = 1'b1;
            default:  o_req_ready = 1'b0;
        endcase
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_mem_addr   = {word_q, 2'b00};
    assign o_mem_wdata  = wdata_q;
    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;

endmodule

// File: doc/riscv_core_amo_unit.md
Name: riscv_core_amo_unit

Overview:
- Memory-side sequencer for RV32A atomics.
- Accepts an AMO/LR/SC request from the core MEM stage, then performs the read-modify-write on the data-memory port.
- Computes the new value with the 4-bit AMO op encoding below, holds the LR reservation, and returns the load result to writeback.
- Sits between the core's atomic path and the data-memory arbiter.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 32, byte address width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_req_valid  in  1  core request valid.
- o_req_ready  out  1  unit can accept a request.
- i_req_kind  in  2  00 AMO RMW, 01 LR.W, 10 SC.W, 11 illegal.
- i_req_op  in  4  AMO op code: 0 SWAP, 1 ADD, 2 AND, 3 OR, 4 XOR, 5 MAX, 6 MIN, 7 MAXU, 8 MINU.
- i_req_addr  in  ADDR_WIDTH  byte address.
- i_req_wdata  in  DATA_WIDTH  rs2 operand.
- o_resp_valid  out  1  response valid.
- i_resp_ready  in  1  core accepts response.
- o_resp_rdata  out  DATA_WIDTH  value returned to rd.
- o_resp_err  out  1  access fault or illegal request.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  1 means write.
- o_mem_addr  out  ADDR_WIDTH  word-aligned address.
- o_mem_wdata  out  DATA_WIDTH  write data.
- i_mem_gnt  in  1  request accepted this cycle.
- i_mem_rvalid  in  1  read data valid.
- i_mem_rdata  in  DATA_WIDTH  read data.
- i_mem_err  in  1  fault; qualified by rvalid on reads, by gnt on writes.
- i_store_valid  in  1  ordinary core store committed.
- i_store_addr  in  ADDR_WIDTH  address of that store.
- o_busy  out  1  state is not IDLE.

Behaviour:
- **States:** IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- **Reset values:** state IDLE, reservation invalid, all data registers 0. Outputs during reset: o_req_ready=1, all other outputs 0.
- **IDLE:**
  - o_req_ready=1.
  - On i_req_valid, latch kind, op, addr, wdata.
  - Go to RESP with err=1 and rdata=0, with no memory access, if any of these hold: addr[1:0]!=0; kind==11; kind==AMO with op>8.
  - Otherwise:
    - LR or AMO goes to RD_REQ.
    - SC with reservation valid and reservation word == addr[ADDR_WIDTH-1:2] goes to WR_REQ with write data = wdata.
    - SC without a match goes to RESP with rdata=1 and err=0, with no memory access.
  - Any SC clears the reservation on acceptance.
- **RD_REQ:**
  - o_mem_req=1, o_mem_we=0.
  - Hold addr stable until i_mem_gnt, then go to RD_WAIT.
- **RD_WAIT:**
  - o_mem_req=0.
  - On i_mem_rvalid, latch old=i_mem_rdata.
  - If i_mem_err: go to RESP with err=1, no write, reservation unchanged.
  - LR: set reservation valid with word address; rdata=old; go to RESP.
  - AMO: register new=f(op, old, wdata); go to WR_REQ.
- **AMO op function f:**
  - SWAP gives wdata.
  - ADD is modulo 2^DATA_WIDTH.
  - AND, OR, XOR are bitwise.
  - MAX and MIN use a signed compare; MAXU and MINU use an unsigned compare.
  - Equal operands return old.
- **WR_REQ:**
  - o_mem_req=1, o_mem_we=1, o_mem_wdata=new (AMO) or wdata (SC).
  - Hold until i_mem_gnt.
  - Response value: SC returns rdata=0; AMO returns rdata=old.
  - err=i_mem_err sampled at gnt.
  - An AMO write to the reserved word clears the reservation.
  - Go to RESP.
- **RESP:**
  - o_resp_valid=1; rdata and err held stable until i_resp_ready, then go to IDLE.
  - No new request is accepted in the same cycle (one idle cycle minimum between operations).
- **Reservation clear:** i_store_valid whose word address matches the reservation clears it in any state.
  - If it coincides with an LR setting the reservation in RD_WAIT, the clear wins and the reservation ends invalid.
- **Latency:** with zero-wait memory (gnt in the request cycle, rvalid the following cycle) and accept at cycle T0, o_resp_valid rises at:
  - AMO: T4.
  - LR: T3.
  - SC success: T2.
  - SC fail or error: T1.
- **Reset mid-operation:** the FSM aborts to IDLE immediately and o_mem_req drops asynchronously. A partial RMW is not completed.
- **Outputs:** o_mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}; o_busy=(state!=IDLE).

Test Plan:
- AMOADD at 0x100, mem=0x7FFFFFFF, wdata=1, zero-wait -> write 0x80000000, rdata=0x7FFFFFFF, resp_valid at T4.
- AMOMAX vs AMOMAXU, mem=0xFFFFFFFF, wdata=0x00000001 -> signed writes 0x00000001, unsigned writes 0xFFFFFFFF; both return 0xFFFFFFFF.
- LR.W 0x200 then SC.W 0x200 wdata=0xA5 -> write 0xA5, SC rdata=0. A second SC.W 0x200 -> no mem_req, rdata=1.
- LR.W 0x200, then i_store_valid addr 0x202 before SC -> SC fails, rdata=1, no write. Repeat with the store coincident with LR rvalid -> SC fails.
- AMO addr 0x101 -> err=1, rdata=0, no mem_req. Op=9 -> err=1. i_mem_err on the read -> err=1 and no write issued.
- Stall gnt 3 cycles in RD_REQ and hold i_resp_ready low 2 cycles -> addr and wdata stable, resp held. Assert i_rst in WR_REQ -> o_mem_req=0 immediately, IDLE after release.
